// File: rtl/alu_mul_seq.sv
// Iterative unsigned 32x32 shift-and-add multiplier that borrows the core's shared ALU.
// Define ALU_MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        alu_own,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_result
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLTU = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CARRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] p_hi_r;
    logic [31:0] p_lo_r;
    logic [31:0] mcand_r;
    logic [31:0] sum_r;
    logic [5:0]  cnt_r;
    logic        op_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        alu_own_r;
    logic        last_iter_s;

    assign last_iter_s = (cnt_r == 6'd31);

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    logic [31:0] rem_mask_s;
    logic        rem_zero_s;
    logic [63:0] exit_shift_s;

    // Remaining multiplier bits sit in P_lo[31-cnt:0]; all-zero means only shifting is left.
    assign rem_mask_s   = 32'hFFFF_FFFF >> cnt_r;
    assign rem_zero_s   = ((p_lo_r & rem_mask_s) == 32'd0);
    assign exit_shift_s = {p_hi_r, p_lo_r} >> (6'd32 - cnt_r);
`endif

    // Sequencer state, product registers and registered handshake/ownership flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            p_hi_r      <= 32'd0;
            p_lo_r      <= 32'd0;
            mcand_r     <= 32'd0;
            sum_r       <= 32'd0;
            cnt_r       <= 6'd0;
            op_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            alu_own_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        p_hi_r     <= 32'd0;
                        p_lo_r     <= in_b;
                        mcand_r    <= in_a;
                        op_r       <= in_op;
                        cnt_r      <= 6'd0;
                        in_ready_r <= 1'b0;
                        alu_own_r  <= 1'b1;
                        state_r    <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                    if (rem_zero_s) begin
                        {p_hi_r, p_lo_r} <= exit_shift_s;
                        cnt_r            <= 6'd32;
                        alu_own_r        <= 1'b0;
                        out_valid_r      <= 1'b1;
                        state_r          <= DONE;
                    end else
`endif
                    if (p_lo_r[0]) begin
                        // Partial sum comes straight from the shared ALU this cycle.
                        sum_r   <= alu_result;
                        state_r <= CARRY;
                    end else begin
                        {p_hi_r, p_lo_r} <= {1'b0, p_hi_r, p_lo_r[31:1]};
                        cnt_r            <= cnt_r + 6'd1;
                        if (last_iter_s) begin
                            alu_own_r   <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= ADD;
                        end
                    end
                end
                CARRY: begin
                    // sum < mcand (unsigned) exactly when the 32-bit add wrapped.
                    p_hi_r <= {alu_result[0], sum_r[31:1]};
                    p_lo_r <= {sum_r[0], p_lo_r[31:1]};
                    cnt_r  <= cnt_r + 6'd1;
                    if (last_iter_s) begin
                        alu_own_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= ADD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    alu_own_r   <= 1'b0;
                end
            endcase
        end
    end

    // Shared-ALU operand/opcode selection, decoded from registered state only.
    always_comb begin
        alu_srcA = 32'd0;
        alu_srcB = 32'd0;
        alu_sel  = ALU_ADD;
        case (state_r)
            ADD: begin
                alu_srcA = p_hi_r;
                alu_srcB = mcand_r;
                alu_sel  = ALU_ADD;
            end
            CARRY: begin
                alu_srcA = sum_r;
                alu_srcB = mcand_r;
                alu_sel  = ALU_SLTU;
            end
            default: begin
                alu_srcA = 32'd0;
                alu_srcB = 32'd0;
                alu_sel  = ALU_ADD;
            end
        endcase
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign alu_own    = alu_own_r;
    assign out_result = out_valid_r ? (op_r ? p_hi_r : p_lo_r) : 32'd0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq against a plain-arithmetic product/latency model.
module tb_alu_mul_seq;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLTU = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        alu_own;
    logic [31:0] alu_srcA;
    logic [31:0] alu_srcB;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in for the core's combinational ALU.
    assign alu_result = (alu_sel == ALU_ADD)  ? (alu_srcA + alu_srcB) :
                        (alu_sel == ALU_SLTU) ? {31'd0, (alu_srcA < alu_srcB)} : 32'd0;

    alu_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .alu_own   (alu_own),
        .alu_srcA  (alu_srcA),
        .alu_srcB  (alu_srcB),
        .alu_sel   (alu_sel),
        .alu_result(alu_result)
    );

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Cycles from the accept edge to out_valid.
    function automatic int exp_latency(input logic [31:0] b);
        int pop;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        int h;
        pop = $countones(b);
        h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
        return 1 + h + pop + ((h < 32) ? 1 : 0);
`else
        pop = $countones(b);
        return 33 + pop;
`endif
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op, input int stall);
        logic [63:0] prod;
        logic [31:0] want;
        int          lat;
        int          guard;
        int          n_sltu;
        logic        own_ok;
        logic        busy_ok;
        logic        stall_ok;

        prod = {32'd0, a} * {32'd0, b};
        want = op ? prod[63:32] : prod[31:0];
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_req", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        @(posedge clk);
        @(negedge clk);
        lat     = 1;
        n_sltu  = 0;
        own_ok  = 1'b1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            own_ok  = own_ok & alu_own;
            busy_ok = busy_ok & !in_ready;
            if (alu_sel == ALU_SLTU) n_sltu++;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = $urandom;
            in_b     = $urandom;
            in_op    = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", 64'(lat), 64'(exp_latency(b)));
        check_eq("result", {32'd0, out_result}, {32'd0, want});
        check_eq("alu_own_busy", {63'd0, own_ok}, 64'd1);
        check_eq("in_ready_busy", {63'd0, busy_ok}, 64'd1);
        check_eq("sltu_iterations", 64'(n_sltu), 64'($countones(b)));
        check_eq("alu_own_done", {63'd0, alu_own}, 64'd0);
        stall_ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = $urandom;
            in_b     = $urandom;
            @(negedge clk);
            stall_ok = stall_ok & out_valid & !in_ready & (out_result == want);
        end
        in_valid = 1'b0;
        if (stall > 0) check_eq("stall_hold", {63'd0, stall_ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("idle_after_hs", {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_flags", {62'd0, out_valid, alu_own}, 64'd0);
        check_eq("rst_result", {32'd0, out_result}, 64'd0);
        check_eq("rst_alu_bus", {28'd0, alu_sel, alu_srcA}, {28'd0, ALU_ADD, 32'd0});

        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h8000_0000, 32'h0000_0003, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0003, 1'b0, 0);
        do_op(32'h0001_0000, 32'h0003_0000, 1'b1, 5);
        do_op(32'h0000_0005, 32'h0000_0001, 1'b0, 0);

        // Abandon an operation in the middle of a CARRY cycle.
        in_valid = 1'b1;
        in_a     = 32'h0000_1234;
        in_b     = 32'h0000_00FF;
        in_op    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (alu_sel != ALU_SLTU && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reached_carry", {60'd0, alu_sel}, {60'd0, ALU_SLTU});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_state", {61'd0, in_ready, out_valid, alu_own}, 64'd4);
        do_op(32'd7, 32'd6, 1'b0, 0);

        for (int k = 0; k < 24; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 1) rb = rb >> $urandom_range(8, 31);
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
